ln_sum_unit: RTL and testbench
==============================

Name: ln_sum_unit

Overview:
- Softmax stage-2/3 block on the log side of the exp datapath.
- Accumulates a stream of unsigned fixed-point exp values into F.
- Converts F to lnF by inverting the exp preprocess: finds log2(F) with a leading-one detector plus a Mitchell linear mantissa, then multiplies by ln2.
- lnF is returned as 22.10 two's-complement and held for the stage-4 subtraction path.

Parameters:
- DATA_W, 32, input/output word width (matches `OUTPUT_BUF_DATASIZE).
- FRAC_W, 10, fraction bits of inputs and lnF (matches `FIXPOINT_FRAC).
- ACC_W, 40, accumulator width (DATA_W+8).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  exp sample valid.
- in_ready  out  1  unit can accept a sample.
- in_data  in  DATA_W  unsigned exp value, FRAC_W fraction bits.
- in_last  in  1  marks the final sample of the row.
- out_valid  out  1  lnF valid.
- out_ready  in  1  consumer accepts lnF.
- out_lnF  out  DATA_W  signed ln(F), FRAC_W fraction bits.
- out_zero  out  1  F was 0; out_lnF is forced to the most-negative value.
- out_ovf  out  1  accumulator saturated during this row.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous, active-high.
- Reset values: state=IDLE; acc=0; out_valid=0; out_lnF=0; out_zero=0; out_ovf=0; in_ready=1.
- Reset mid-operation discards the partial row and any pending result.
- FSM states: IDLE, ACC, LOD, MUL, OUT.
  - in_ready=1 only in IDLE and ACC.
  - A beat is accepted when in_valid && in_ready.
- IDLE:
  - Accept: acc<=zero-extended in_data and ovf<=0.
  - Then go to LOD if in_last, else to ACC.
- ACC:
  - Accept: acc<=acc+in_data, saturating to all-ones on carry-out; a saturation sets ovf (sticky for the row).
  - If in_last, go to LOD.
- LOD (1 cycle), registered results:
  - p = index of the most significant 1 in acc.
  - k = p-FRAC_W, signed.
  - m = the FRAC_W bits immediately below bit p, left-justified and zero-filled when p<FRAC_W.
  - zero = (acc==0).
- MUL (1 cycle):
  - L = (k<<FRAC_W)+m, signed DATA_W.
  - y = (L>>>1)+(L>>>3)+(L>>>4), i.e. ln2 ≈ 0.1011b, using arithmetic shifts that floor.
  - If zero: y = 1 followed by DATA_W-1 zeros (0x80000000).
  - Register out_lnF, out_zero and out_ovf; go to OUT.
- OUT:
  - out_valid=1; out_lnF, out_zero and out_ovf are held stable.
  - On out_ready: out_valid falls next cycle and the FSM returns to IDLE.
- Latency: the final beat is accepted in cycle t; out_valid=1 in cycle t+3 (IDLE/ACC→LOD→MUL→OUT). Throughput is one row per (N+3+stall) cycles.
- in_valid is ignored outside IDLE/ACC, so there is no overlap between rows.
- A single-beat row (in_last on the first beat) is legal.
- No output FIFO: one result is pending at most.

Decomposition:
- Shared softmax package/header holds:
  - DATA_W/FRAC_W defaults tied to `OUTPUT_BUF_DATASIZE/`FIXPOINT_FRAC.
  - FSM state encodings.
  - The ln2 shift set {1,3,4}, paired with the log2e set {0,1,-4} used by the exp preprocess.
- One sub-module, lod_normalize:
  - Combinational priority encoder plus barrel shift.
  - acc → {p, m, zero}.
  - Instantiated once, with its outputs registered in LOD.

Test Plan:
- Single beat 0x00000400 (1.0), in_last=1 → out_lnF=0x00000000, out_zero=0, out_valid exactly 3 cycles after acceptance.
- Single beat 0x00000800 (2.0) → L=1024, out_lnF=704 (0x2C0); four beats of 0x400 (F=4.0) → out_lnF=1408 (0x580).
- Beats 0x400 then 0x800 (F=3.0): p=11, m=512, L=1536 → out_lnF=1056 (0x420). Single beat 0x200 (0.5) → out_lnF=0xFFFFFD40 (-704).
- Single beat 0 → out_zero=1, out_lnF=0x80000000. Beats summing past 2^40-1 (e.g. 300×0xFFFFFFFF) → out_ovf=1, acc saturated.
- Hold out_ready=0 for 5 cycles:
  - out_valid and out_lnF stay stable and in_ready=0.
  - in_valid pulses are not accepted.
  - On release, the next row starts fresh from acc=in_data.
- Assert rst during ACC after 3 beats → next cycle all outputs are at reset values; a following single 0x400 row yields out_lnF=0.

Source files
------------

// File: rtl/ln_sum_unit_pkg.sv
// rtl/ln_sum_unit_pkg.sv - shared softmax log-side widths, FSM encoding and ln2/log2e shift sets
package ln_sum_unit_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_FRAC_W = 10;
  localparam int DEF_ACC_W  = DEF_DATA_W + 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    LOD  = 3'd2,
    MUL  = 3'd3,
    OUT  = 3'd4
  } state_t;

  // ln2 ~= 0.1011b; inverse of the exp-side log2e ~= 1.0111b = x + x/2 - x/16
  localparam int unsigned LN2_SH0 = 1;
  localparam int unsigned LN2_SH1 = 3;
  localparam int unsigned LN2_SH2 = 4;

  function automatic logic signed [31:0] log2e_scale(input logic signed [31:0] x);
    return x + (x >>> 1) - (x >>> 4);
  endfunction

endpackage

// File: rtl/ln_sum_unit_lod_normalize.sv
// rtl/ln_sum_unit_lod_normalize.sv - leading-one detector plus left-justified mantissa extract
module ln_sum_unit_lod_normalize #(
  parameter int ACC_W  = 40,
  parameter int FRAC_W = 10,
  parameter int P_W    = $clog2(ACC_W)
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [P_W-1:0]    p,
  output logic [FRAC_W-1:0] m,
  output logic              zero
);

  logic [ACC_W-1:0] norm;

  always_comb begin
    p = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (acc[i]) p = P_W'(i);
    end
    // Leading one moved to the MSB; the bits under it are the mantissa, zero-filled from below
    norm = acc << (ACC_W - 1 - int'(p));
    m    = norm[ACC_W-2 -: FRAC_W];
    zero = (acc == '0);
  end

endmodule

// File: rtl/ln_sum_unit.sv
// rtl/ln_sum_unit.sv - accumulates exp samples into F and returns ln(F) in signed fixed point
module ln_sum_unit
  import ln_sum_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_lnF,
  output logic              out_zero,
  output logic              out_ovf
);

  localparam int P_W = $clog2(ACC_W);
  localparam int K_W = P_W + 1;
  localparam int S_W = ACC_W + 1;

  state_t state, state_nxt;

  logic [ACC_W-1:0]         acc;
  logic                     ovf;
  logic [ACC_W:0]           sum;
  logic                     accept;
  logic [P_W-1:0]           lod_p;
  logic [FRAC_W-1:0]        lod_m;
  logic                     lod_zero;
  logic signed [K_W-1:0]    k_q;
  logic [FRAC_W-1:0]        m_q;
  logic                     zero_q;
  logic signed [DATA_W-1:0] l_val;
  logic signed [DATA_W-1:0] y_val;

  ln_sum_unit_lod_normalize #(
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W),
    .P_W    (P_W)
  ) u_lod (
    .acc  (acc),
    .p    (lod_p),
    .m    (lod_m),
    .zero (lod_zero)
  );

  assign accept = in_valid && in_ready;
  assign sum    = {1'b0, acc} + S_W'(in_data);
  // log2(F) = k + m/2^FRAC_W, with m < 2^FRAC_W so it simply sits under k
  assign l_val  = {{(DATA_W-FRAC_W-K_W){k_q[K_W-1]}}, k_q, m_q};
  assign y_val  = (l_val >>> LN2_SH0) + (l_val >>> LN2_SH1) + (l_val >>> LN2_SH2);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE, ACC: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? LOD : ACC;
      end
      LOD:     state_nxt = MUL;
      MUL:     state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      ovf      <= 1'b0;
      k_q      <= '0;
      m_q      <= '0;
      zero_q   <= 1'b0;
      out_lnF  <= '0;
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc <= ACC_W'(in_data);
          ovf <= 1'b0;
        end
        ACC: if (accept) begin
          if (sum[ACC_W]) begin
            acc <= '1;
            ovf <= 1'b1;
          end else begin
            acc <= sum[ACC_W-1:0];
          end
        end
        LOD: begin
          k_q    <= K_W'(lod_p) - K_W'(FRAC_W);
          m_q    <= lod_m;
          zero_q <= lod_zero;
        end
        MUL: begin
          out_lnF  <= zero_q ? {1'b1, {(DATA_W-1){1'b0}}} : y_val;
          out_zero <= zero_q;
          out_ovf  <= ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ln_sum_unit.sv
// tb/tb_ln_sum_unit.sv - table-driven and scoreboard bench for ln_sum_unit
module tb_ln_sum_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_lnF;
  logic        out_zero;
  logic        out_ovf;

  always #5 clk = ~clk;

  ln_sum_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lnF   (out_lnF),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  typedef struct {
    logic [31:0] ln;
    bit          zero;
    bit          ovf;
  } exp_t;

  typedef struct {
    int          n;
    logic [31:0] first;
    logic [31:0] rest;
    logic [31:0] ln;
    bit          zero;
    bit          ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_ln(input longint unsigned f);
    int p;
    int k;
    int m;
    int l;
    if (f == 0) return 32'h8000_0000;
    p = 0;
    for (int i = 0; i < 40; i++) if (f[i]) p = i;
    k = p - 10;
    if (p >= 10) m = int'((f >> (p - 10)) & 64'h3FF);
    else         m = int'((f << (10 - p)) & 64'h3FF);
    l = k * 1024 + m;
    return 32'((l >>> 1) + (l >>> 3) + (l >>> 4));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_row(input int n, input logic [31:0] first, input logic [31:0] rest,
                          input logic [31:0] ln, input bit zero, input bit ovf);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        e.ln = ln; e.zero = zero; e.ovf = ovf;
        sb.push_back(e);
      end
      send_beat(i == 0 ? first : rest, i == n - 1);
    end
  endtask

  task automatic collect(input int stall);
    int          waited = 0;
    exp_t        e;
    logic [31:0] held;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    check("latency", waited, 32'd2);
    held = out_lnF;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_data  = 32'h0000_1234;
      in_last  = 1'b1;
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_lnF_stable", out_lnF, held);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("out_lnF", out_lnF, e.ln);
      check("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
      check("out_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    longint unsigned f;
    logic [31:0]     a;
    logic [31:0]     b;
    int              n;
    bit              ov;

    vecs[0] = '{1,   32'h0000_0400, 32'h0000_0400, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{1,   32'h0000_0800, 32'h0000_0800, 32'h0000_02C0, 1'b0, 1'b0};
    vecs[2] = '{4,   32'h0000_0400, 32'h0000_0400, 32'h0000_0580, 1'b0, 1'b0};
    vecs[3] = '{2,   32'h0000_0400, 32'h0000_0800, 32'h0000_0420, 1'b0, 1'b0};
    vecs[4] = '{1,   32'h0000_0200, 32'h0000_0200, 32'hFFFF_FD40, 1'b0, 1'b0};
    vecs[5] = '{1,   32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0};
    vecs[6] = '{300, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_527D, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_lnF", out_lnF, 32'd0);
    check("rst_out_flags", {30'd0, out_zero, out_ovf}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      send_row(vecs[i].n, vecs[i].first, vecs[i].rest, vecs[i].ln, vecs[i].zero, vecs[i].ovf);
      collect(0);
    end
    // ovf must not leak from the saturated row
    send_row(1, 32'h0000_0400, 32'h0000_0400, 32'h0000_0000, 1'b0, 1'b0);
    collect(0);

    for (int r = 0; r < 8; r++) begin
      n  = $urandom_range(1, 5);
      a  = (r % 2 == 0) ? $urandom : 32'($urandom_range(1, 4095));
      b  = 32'($urandom_range(0, 65535));
      f  = a;
      ov = 1'b0;
      for (int j = 1; j < n; j++) begin
        f = f + b;
        if (f > 64'hFF_FFFF_FFFF) begin f = 64'hFF_FFFF_FFFF; ov = 1'b1; end
      end
      send_row(n, a, b, model_ln(f), f == 0, ov);
      collect(0);
    end

    send_row(1, 32'h0000_0800, 32'h0000_0800, 32'h0000_02C0, 1'b0, 1'b0);
    collect(5);
    send_row(1, 32'h0000_0400, 32'h0000_0400, 32'h0000_0000, 1'b0, 1'b0);
    collect(0);

    send_row(4, 32'h0000_0400, 32'h0000_0400, 32'h0000_0580, 1'b0, 1'b0);
    collect(0);
    for (int i = 0; i < 3; i++) send_beat(32'h0000_0900, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_lnF", out_lnF, 32'd0);
    check("midrst_out_flags", {30'd0, out_zero, out_ovf}, 32'd0);
    send_row(1, 32'h0000_0400, 32'h0000_0400, 32'h0000_0000, 1'b0, 1'b0);
    collect(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
